// File: rtl/ramcard_pkg.sv
// rtl/ramcard_pkg.sv - shared types and constants for the card SRAM arbiter
package ramcard_pkg;

    localparam int RAM_ADDR_W = 18;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_e;

    typedef enum logic {
        CPU = 1'b0,
        VID = 1'b1
    } grant_e;

endpackage

// File: rtl/ramcard_arbiter.sv
// rtl/ramcard_arbiter.sv - CPU/video arbiter and access sequencer for the card SRAM
module ramcard_arbiter
    import ramcard_pkg::*;
#(
    parameter int ACCESS_CYCLES = 3,
    parameter int ADDR_W        = RAM_ADDR_W
) (
    input  logic              mclk28,
    input  logic              reset_in_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [7:0]        vid_rdata,
    output logic              vid_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_dout,
    input  logic [7:0]        mem_din,
    output logic              mem_ce_n,
    output logic              mem_oe_n,
    output logic              mem_we_n,
    output logic              mem_dout_en
);

    localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

    state_e            state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    grant_e            owner_q, owner_d;
    logic              wr_q, wr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_ce_n_q, mem_ce_n_d;
    logic              mem_oe_n_q, mem_oe_n_d;
    logic              mem_we_n_q, mem_we_n_d;
    logic              mem_dout_en_q, mem_dout_en_d;
    logic [7:0]        cpu_rdata_q, cpu_rdata_d;
    logic [7:0]        vid_rdata_q, vid_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              vid_ack_q, vid_ack_d;
    grant_e            pick;
    logic              pick_wr;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        wr_d          = wr_q;
        cnt_d         = cnt_q;
        mem_addr_d    = mem_addr_q;
        mem_dout_d    = mem_dout_q;
        mem_ce_n_d    = mem_ce_n_q;
        mem_oe_n_d    = mem_oe_n_q;
        mem_we_n_d    = mem_we_n_q;
        mem_dout_en_d = mem_dout_en_q;
        cpu_rdata_d   = cpu_rdata_q;
        vid_rdata_d   = vid_rdata_q;
        cpu_ack_d     = 1'b0;
        vid_ack_d     = 1'b0;
        pick          = CPU;
        pick_wr       = 1'b0;

        case (state_q)
            IDLE: begin
                // Under contention the side that did not win last time goes first
                if (cpu_req && vid_req) begin
                    pick = (last_grant_q == CPU) ? VID : CPU;
                end else if (vid_req) begin
                    pick = VID;
                end
                pick_wr = (pick == CPU) && cpu_we;

                if (cpu_req || vid_req) begin
                    owner_d       = pick;
                    last_grant_d  = pick;
                    wr_d          = pick_wr;
                    mem_addr_d    = (pick == CPU) ? cpu_addr : vid_addr;
                    mem_dout_d    = pick_wr ? cpu_wdata : mem_dout_q;
                    mem_ce_n_d    = 1'b0;
                    mem_oe_n_d    = pick_wr;
                    mem_we_n_d    = !pick_wr;
                    mem_dout_en_d = pick_wr;
                    cnt_d         = CNT_INIT;
                    state_d       = ACCESS;
                end
            end

            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!wr_q) begin
                        if (owner_q == CPU) cpu_rdata_d = mem_din;
                        else                vid_rdata_d = mem_din;
                    end
                    cpu_ack_d  = (owner_q == CPU);
                    vid_ack_d  = (owner_q == VID);
                    mem_ce_n_d = 1'b1;
                    mem_oe_n_d = 1'b1;
                    mem_we_n_d = 1'b1;
                    state_d    = RECOVER;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    // Final strobe cycle holds address and data with WE already released
                    if (wr_q && cnt_q == 4'd1) mem_we_n_d = 1'b1;
                end
            end

            RECOVER: begin
                mem_dout_en_d = 1'b0;
                state_d       = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge mclk28 or negedge reset_in_n) begin
        if (!reset_in_n) begin
            state_q       <= IDLE;
            last_grant_q  <= VID;
            owner_q       <= CPU;
            wr_q          <= 1'b0;
            cnt_q         <= 4'd0;
            mem_addr_q    <= '0;
            mem_dout_q    <= 8'h00;
            mem_ce_n_q    <= 1'b1;
            mem_oe_n_q    <= 1'b1;
            mem_we_n_q    <= 1'b1;
            mem_dout_en_q <= 1'b0;
            cpu_rdata_q   <= 8'h00;
            vid_rdata_q   <= 8'h00;
            cpu_ack_q     <= 1'b0;
            vid_ack_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            wr_q          <= wr_d;
            cnt_q         <= cnt_d;
            mem_addr_q    <= mem_addr_d;
            mem_dout_q    <= mem_dout_d;
            mem_ce_n_q    <= mem_ce_n_d;
            mem_oe_n_q    <= mem_oe_n_d;
            mem_we_n_q    <= mem_we_n_d;
            mem_dout_en_q <= mem_dout_en_d;
            cpu_rdata_q   <= cpu_rdata_d;
            vid_rdata_q   <= vid_rdata_d;
            cpu_ack_q     <= cpu_ack_d;
            vid_ack_q     <= vid_ack_d;
        end
    end

    assign cpu_rdata   = cpu_rdata_q;
    assign cpu_ack     = cpu_ack_q;
    assign vid_rdata   = vid_rdata_q;
    assign vid_ack     = vid_ack_q;
    assign mem_addr    = mem_addr_q;
    assign mem_dout    = mem_dout_q;
    assign mem_ce_n    = mem_ce_n_q;
    assign mem_oe_n    = mem_oe_n_q;
    assign mem_we_n    = mem_we_n_q;
    assign mem_dout_en = mem_dout_en_q;

endmodule

// File: doc/ramcard_arbiter.md
Name: ramcard_arbiter

Overview:
- Shares the external card SRAM (18-bit address, 8-bit data) between two requesters: the CPU side (ram_addr/card_ram_rd/card_ram_we from the language/Saturn card mapper) and the video fetch engine.
- Sequences every access: fixed-length read and write strobes, a turnaround cycle after each access, and a registered one-cycle acknowledge.
- Sits between the card mapper, the video scanner and the SRAM pins, in the mclk28 domain.

Parameters:
- ACCESS_CYCLES, 3, number of mclk28 cycles the SRAM is selected per access. Legal range 2..15.
- ADDR_W, 18, SRAM address width.

Ports:
- mclk28 in 1: system clock, 28 MHz.
- reset_in_n in 1: asynchronous, active-low reset.
- cpu_req in 1: CPU access request. Level signal, held until cpu_ack.
- cpu_we in 1: 1 = write, 0 = read. Valid while cpu_req is high.
- cpu_addr in ADDR_W: CPU address, from mapper ram_addr.
- cpu_wdata in 8: CPU write data.
- cpu_rdata out 8: CPU read data. Valid on the cpu_ack cycle and held afterwards.
- cpu_ack out 1: one-cycle completion pulse.
- vid_req in 1: video read request. Level signal, held until vid_ack.
- vid_addr in ADDR_W: video address.
- vid_rdata out 8: video read data. Valid on the vid_ack cycle and held afterwards.
- vid_ack out 1: one-cycle completion pulse.
- mem_addr out ADDR_W: SRAM address.
- mem_dout out 8: SRAM write data.
- mem_din in 8: SRAM read data.
- mem_ce_n out 1: SRAM chip enable, active-low.
- mem_oe_n out 1: SRAM output enable, active-low.
- mem_we_n out 1: SRAM write enable, active-low.
- mem_dout_en out 1: drive enable for the bidirectional data pad.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, takes effect immediately, including mid-access):
  - state = IDLE.
  - mem_ce_n, mem_oe_n, mem_we_n = 1; mem_dout_en = 0.
  - mem_addr, mem_dout, cpu_rdata, vid_rdata = 0.
  - cpu_ack, vid_ack = 0.
  - last_grant = VID, so the CPU wins the first contention.
  - An aborted access produces no ack. The requester re-issues it.
- FSM states: IDLE, ACCESS, RECOVER.
- IDLE:
  - No request pending: stay in IDLE.
  - Only one request pending: grant that requester.
  - Both pending: grant the requester that is not last_grant (strict alternation). Update last_grant.
  - On the grant edge:
    - Latch address and write data into mem_addr/mem_dout.
    - mem_ce_n = 0.
    - Read: mem_oe_n = 0.
    - CPU write: mem_we_n = 0 and mem_dout_en = 1.
    - cnt = ACCESS_CYCLES-1.
    - Go to ACCESS.
  - Video requests are always reads.
- ACCESS:
  - cnt decrements each edge.
  - Write, edge where cnt goes 1 -> 0: mem_we_n = 1. The last access cycle is data/address hold with WE high.
  - Edge where cnt == 0:
    - Read: capture mem_din into the granted requester's rdata.
    - Pulse that requester's ack for one cycle.
    - mem_ce_n = mem_oe_n = mem_we_n = 1.
    - Go to RECOVER.
  - mem_dout_en falls one cycle later, on the RECOVER -> IDLE edge.
- RECOVER:
  - Bus turnaround. Requests are ignored.
  - Next edge: go to IDLE, mem_dout_en = 0.
- Latency: a request sampled in IDLE at edge E gets its ack high in the cycle after edge E+ACCESS_CYCLES. Back-to-back period is ACCESS_CYCLES+2 cycles.
- Requester rule: drop req in the cycle after ack is seen. A req still high when IDLE is re-entered is treated as a new request.
- A requester that drops req before ack does not abort an access in flight; the access completes and acks anyway.
- mem_addr and mem_dout are stable for the whole ACCESS and RECOVER states.
- cpu_ack and vid_ack are never high in the same cycle.
- cnt width: 4 bits.

Decomposition:
- Shared package ramcard_pkg:
  - state enum {IDLE, ACCESS, RECOVER}.
  - grant enum {CPU, VID}.
  - Constant RAM_ADDR_W = 18, shared with the card mapper.
- No sub-module needed. Arbitration, FSM and pin registers stay in one block of roughly 150-200 lines.

Test Plan (ACCESS_CYCLES=3):
- CPU read, addr 0x2_1234, mem_din = 0xA5 -> mem_ce_n/mem_oe_n low for 3 cycles, cpu_ack one cycle 4 edges after request sampled, cpu_rdata = 0xA5, mem_we_n stays 1.
- CPU write, addr 0x0_D000, data 0x3C -> mem_we_n low for exactly 2 cycles, ce_n low for 3, mem_dout = 0x3C, mem_dout_en high for 4 cycles, cpu_ack pulse.
- cpu_req and vid_req raised together from reset, held -> order CPU, VID, CPU, VID. Grants 5 cycles apart. Acks never coincide.
- vid_req alone, continuous, re-raised after each ack -> one access every 5 cycles, vid_rdata tracks mem_din.
- reset_in_n low during the 2nd ACCESS cycle of a write -> mem_we_n/mem_ce_n = 1 immediately, no cpu_ack, state IDLE on release. The next contended grant goes to CPU.
- cpu_req dropped during ACCESS -> access completes, cpu_ack still pulses, no second access.
